key_collector: RTL and testbench
================================

// Module: key_collector
// PURPOSE
//  Downstream of the search-unit group: drains the 32-bit key stream popped from the group's key queue.
//  Discards filler keys and packs pairs of keys into 64-bit words.
//  Buffers the words in a small FIFO that the processor reads through a pop handshake.
//  Keeps sticky overflow status and a key count for software.
// PARAMETERS
//  DEPTH   8   64-bit words in the output FIFO (power of 2, >=2)
//  CNT_W   16  width of key_count / drop_count (saturating)
// PORTS
//  clk         in   1   single clock; all state on rising edge
//  rst         in   1   asynchronous, active-low reset
//  clear       in   1   sync: empty FIFO, drop half word, zero counters and overflow
//  key_in      in   32  key from group queue dout
//  key_valid   in   1   key_in valid this cycle (integration: registered ~Qempty)
//  flush       in   1   1-cycle pulse: push pending half word, padded
//  data_rd     in   1   pop head word; ignored when data_valid=0
//  data_out    out  64  head word (first-word-fall-through); {key_hi, key_lo}
//  data_valid  out  1   FIFO non-empty
//  full        out  1   FIFO holds DEPTH words
//  half_pend   out  1   one key held in pack register
//  overflow    out  1   sticky: a word was dropped on full
//  key_count   out  CNT_W  keys accepted into words (saturates at all-ones)
//  drop_count  out  CNT_W  keys lost to overflow (saturates)
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, pack state EMPTY, outputs data_valid=0, full=0, half_pend=0,
//   overflow=0, counters=0, data_out=0.
//  Filter: key_valid with key_in==32'hFFFF_FFFF (group mux default) is ignored: no state change, no count.
//  Pack FSM, two states:
//   EMPTY: valid key -> lo<=key_in, go HALF.
//   HALF:  valid key -> push {key_in, lo}, go EMPTY.
//   HALF:  flush w/o key -> push {32'hFFFF_FFFF, lo}, go EMPTY.
//   HALF:  flush with key same cycle -> key completes word normally; flush is no-op.
//   EMPTY: flush -> no-op.
//  Latency: completing key at edge N -> word visible on data_out/data_valid after edge N (next cycle).
//  Push when full and no data_rd same cycle -> word dropped; overflow<=1; drop_count += keys in word
//   (2, or 1 if flush-padded); key_count unchanged; pack FSM still returns EMPTY.
//  Push + data_rd same cycle when full -> both happen; no drop; full stays 1.
//  Push + data_rd when empty -> push only; the word becomes head next cycle.
//  key_count += 2 per stored full word, +1 per stored padded word.
//  Both counters saturate, never wrap.
//  FIFO pointers are log2(DEPTH)+1 bits; wrap is natural; full = MSB differs and rest equal.
//  clear dominates same-cycle key, flush and data_rd. overflow clears only on clear or rst.
//  Reset mid-word discards the held half word; no partial output.
// STRUCTURE
//  Shared package key_pkg: KEY_W=32, WORD_W=64, KEY_FILLER=32'hFFFF_FFFF, pack-state enum {PK_EMPTY, PK_HALF}.
//  Sub-module key_fifo (WIDTH, DEPTH): sync FWFT FIFO with push/pop/full/empty and async active-low reset.
//  Top level: pack FSM, filter, counters, drop logic.
// TESTING
//  1: After reset, keys 0x11,0x22 on consecutive cycles -> next cycle data_out=0x00000022_00000011,
//     data_valid=1, key_count=2.
//  2: Key 0xFFFFFFFF interleaved between 0x1 and 0x2 -> ignored; word {0x2,0x1}; key_count=2.
//  3: Key 0x5 then flush -> word {0xFFFFFFFF,0x5}; key_count=1; half_pend 1->0.
//  4: Fill 8 words with no reads, send 2 more keys -> full=1, overflow=1, drop_count=2, head word unchanged.
//  5: Full FIFO, complete a word with data_rd in the same cycle -> no drop; new word lands at tail; full stays 1.
//  6: Hold one key, assert rst low mid-cycle -> outputs zero at once; after release, key 0x7 then 0x8 -> {0x8,0x7}.

Source files
------------

// File: rtl/key_pkg.sv
// Shared widths, filler value and pack-state encoding for the key collector.
package key_pkg;
    localparam int KEY_W  = 32;
    localparam int WORD_W = 64;
    localparam logic [KEY_W-1:0] KEY_FILLER = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } packState_t;
endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO with push/pop, sync clear and async active-low reset.
module key_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    // A pop frees the slot the same cycle, so a full FIFO still takes the push.
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear) mem[wrPtr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rdPtr[AW-1:0]];
endmodule

// File: rtl/key_collector.sv
// Filters filler keys, packs key pairs into 64-bit words and queues them for the processor,
// tracking sticky overflow plus saturating key/drop counters.
module key_collector
    import key_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    input  logic              flush,
    input  logic              data_rd,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              half_pend,
    output logic              overflow,
    output logic [CNT_W-1:0]  key_count,
    output logic [CNT_W-1:0]  drop_count
);
    packState_t        packState;
    logic [KEY_W-1:0]  loKey;
    logic              keyOk;
    logic              pushReq;
    logic [WORD_W-1:0] pushWord;
    logic [1:0]        wordKeys;
    logic              popReq;
    logic              fifoEmpty;
    logic              dropWord;
    logic [CNT_W:0]    keySum;
    logic [CNT_W:0]    dropSum;

    assign keyOk = key_valid && (key_in != KEY_FILLER);

    // A real key in HALF completes the word; flush only pads when no key arrives.
    always_comb begin
        pushReq  = 1'b0;
        pushWord = {KEY_FILLER, loKey};
        wordKeys = 2'd1;
        if (packState == PK_HALF) begin
            if (keyOk) begin
                pushReq  = 1'b1;
                pushWord = {key_in, loKey};
                wordKeys = 2'd2;
            end else if (flush) begin
                pushReq = 1'b1;
            end
        end
    end

    assign popReq   = data_rd && !fifoEmpty;
    assign dropWord = pushReq && full && !popReq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            packState <= PK_EMPTY;
            loKey     <= '0;
        end else if (clear) begin
            packState <= PK_EMPTY;
            loKey     <= '0;
        end else if (packState == PK_EMPTY) begin
            if (keyOk) begin
                loKey     <= key_in;
                packState <= PK_HALF;
            end
        end else if (pushReq) begin
            packState <= PK_EMPTY;
        end
    end

    assign keySum  = {1'b0, key_count}  + (CNT_W+1)'(wordKeys);
    assign dropSum = {1'b0, drop_count} + (CNT_W+1)'(wordKeys);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            key_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (dropWord) begin
            overflow   <= 1'b1;
            drop_count <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
        end else if (pushReq) begin
            key_count  <= keySum[CNT_W] ? '1 : keySum[CNT_W-1:0];
        end
    end

    key_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (pushReq),
        .pop   (popReq),
        .din   (pushWord),
        .dout  (data_out),
        .full  (full),
        .empty (fifoEmpty)
    );

    assign data_valid = !fifoEmpty;
    assign half_pend  = (packState == PK_HALF);
endmodule

// File: tb/tb_key_collector.sv
// Randomized and directed checks of key_collector against a queue-based reference model.
module tb_key_collector;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [31:0]       key_in;
    logic              key_valid;
    logic              flush;
    logic              data_rd;
    logic [63:0]       data_out;
    logic              data_valid;
    logic              full;
    logic              half_pend;
    logic              overflow;
    logic [CNT_W-1:0]  key_count;
    logic [CNT_W-1:0]  drop_count;

    key_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .key_in(key_in), .key_valid(key_valid),
        .flush(flush), .data_rd(data_rd), .data_out(data_out), .data_valid(data_valid),
        .full(full), .half_pend(half_pend), .overflow(overflow),
        .key_count(key_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Reference model: list of stored words, pending low key and software counters.
    logic [63:0] mq[$];
    bit          mHalf;
    logic [31:0] mLo;
    bit          mOvf;
    int          mKc;
    int          mDc;
    localparam int CMAX = (1 << CNT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        mHalf = 0;
        mLo   = '0;
        mOvf  = 0;
        mKc   = 0;
        mDc   = 0;
    endfunction

    function automatic void modelStep();
        bit          pop;
        bit          ok;
        bit          doPush;
        logic [63:0] w;
        int          n;
        if (clear) begin
            modelReset();
            return;
        end
        pop    = data_rd && (mq.size() > 0);
        ok     = key_valid && (key_in != 32'hFFFF_FFFF);
        doPush = 0;
        n      = 0;
        w      = '0;
        if (mHalf && ok) begin
            w = {key_in, mLo}; n = 2; doPush = 1; mHalf = 0;
        end else if (mHalf && flush) begin
            w = {32'hFFFF_FFFF, mLo}; n = 1; doPush = 1; mHalf = 0;
        end else if (!mHalf && ok) begin
            mLo = key_in; mHalf = 1;
        end
        if (pop) void'(mq.pop_front());
        if (doPush) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(w);
                mKc = (mKc + n > CMAX) ? CMAX : mKc + n;
            end else begin
                mOvf = 1;
                mDc  = (mDc + n > CMAX) ? CMAX : mDc + n;
            end
        end
    endfunction

    task automatic checkAll(input string tag);
        chk({tag, ".data_out"},   data_out,   (mq.size() > 0) ? mq[0] : 64'h0);
        chk({tag, ".data_valid"}, 64'(data_valid), 64'(mq.size() > 0));
        chk({tag, ".full"},       64'(full),       64'(mq.size() == DEPTH));
        chk({tag, ".half_pend"},  64'(half_pend),  64'(mHalf));
        chk({tag, ".overflow"},   64'(overflow),   64'(mOvf));
        chk({tag, ".key_count"},  64'(key_count),  64'(mKc));
        chk({tag, ".drop_count"}, 64'(drop_count), 64'(mDc));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic idle();
        clear = 0; key_valid = 0; key_in = '0; flush = 0; data_rd = 0;
    endtask

    task automatic sendKey(input logic [31:0] k, input string tag);
        idle();
        key_valid = 1; key_in = k;
        cyc(tag);
        idle();
    endtask

    task automatic doClear();
        idle();
        clear = 1;
        cyc("clear");
        idle();
    endtask

    initial begin
        logic [63:0] firstWord;
        logic [63:0] secondWord;
        idle();
        rst = 0;
        modelReset();
        #12;
        checkAll("reset");
        chk("reset.data_out_zero", data_out, 64'h0);
        @(negedge clk);
        rst = 1;

        // 1: two keys form a word one cycle later
        sendKey(32'h11, "t1a");
        sendKey(32'h22, "t1b");
        chk("t1.word", data_out, 64'h00000022_00000011);
        chk("t1.kc", 64'(key_count), 64'd2);

        // 2: filler key ignored
        doClear();
        sendKey(32'h1, "t2a");
        sendKey(32'hFFFF_FFFF, "t2f");
        chk("t2.half", 64'(half_pend), 64'd1);
        sendKey(32'h2, "t2b");
        chk("t2.word", data_out, 64'h00000002_00000001);
        chk("t2.kc", 64'(key_count), 64'd2);

        // 3: flush pads the held key; flush when empty is a no-op
        doClear();
        flush = 1; cyc("t3noop"); idle();
        chk("t3.noop_valid", 64'(data_valid), 64'd0);
        sendKey(32'h5, "t3a");
        chk("t3.half1", 64'(half_pend), 64'd1);
        flush = 1; cyc("t3flush"); idle();
        chk("t3.half0", 64'(half_pend), 64'd0);
        chk("t3.word", data_out, 64'hFFFFFFFF_00000005);
        chk("t3.kc", 64'(key_count), 64'd1);

        // flush together with a key: key completes the word normally
        doClear();
        sendKey(32'hA, "tfk_a");
        flush = 1; key_valid = 1; key_in = 32'hB; cyc("tfk_b"); idle();
        chk("tfk.word", data_out, 64'h0000000B_0000000A);

        // 4: overfill
        doClear();
        for (int i = 0; i < 2 * DEPTH; i++) sendKey(32'(i + 100), "t4fill");
        firstWord = {32'd101, 32'd100};
        chk("t4.full_pre", 64'(full), 64'd1);
        chk("t4.ovf_pre", 64'(overflow), 64'd0);
        sendKey(32'hC1, "t4x");
        sendKey(32'hC2, "t4y");
        chk("t4.full", 64'(full), 64'd1);
        chk("t4.ovf", 64'(overflow), 64'd1);
        chk("t4.dc", 64'(drop_count), 64'd2);
        chk("t4.head", data_out, firstWord);

        // 5: push with same-cycle pop while full
        sendKey(32'hD1, "t5a");
        key_valid = 1; key_in = 32'hD2; data_rd = 1; cyc("t5b"); idle();
        secondWord = {32'd103, 32'd102};
        chk("t5.full", 64'(full), 64'd1);
        chk("t5.dc", 64'(drop_count), 64'd2);
        chk("t5.head", data_out, secondWord);
        chk("t5.tail", mq[DEPTH-1], 64'h000000D2_000000D1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            data_rd = 1; cyc("t5drain");
        end
        idle();
        chk("t5.tailword", data_out, 64'h000000D2_000000D1);
        chk("t5.ovf_sticky", 64'(overflow), 64'd1);

        // 6: async reset mid-word
        sendKey(32'h9, "t6hold");
        #3;
        rst = 0;
        #1;
        modelReset();
        checkAll("t6rst");
        @(posedge clk);
        #1;
        rst = 1;
        sendKey(32'h7, "t6a");
        sendKey(32'h8, "t6b");
        chk("t6.word", data_out, 64'h00000008_00000007);

        // randomized phases with varying read pressure (counters saturate at CNT_W bits)
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                clear     = ($urandom_range(0, 199) == 0);
                key_valid = ($urandom_range(0, 9) < 6);
                key_in    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
                flush     = ($urandom_range(0, 9) == 0);
                data_rd   = ($urandom_range(0, 9) < (ph * 3));
                cyc("rand");
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
